npu_dot_seq: RTL and testbench
==============================

NPU_DOT_SEQ -- requirements
Module: npu_dot_seq

Interface
REQ-001 Parameter TREE_LAT, default 1: register stages from the tree_data/tree_para/tree_signed inputs of the 8-lane add tree to tree_result.
REQ-002 Parameter ACC_W, default 32: width of the accumulator and of out_result.
REQ-003 clk  input  1  Single clock; all state updates on the rising edge.
REQ-004 rst  input  1  Reset; synchronous, active-high.
REQ-005 start  input  1  Job request; sampled only in IDLE.
REQ-006 cfg_len  input  8  Beat count minus one (1..256 beats); sampled with start.
REQ-007 cfg_signed  input  1  1 = data bytes signed, 0 = unsigned; sampled with start.
REQ-008 busy  output  1  High in every state except IDLE.
REQ-009 in_valid  input  1  Operand beat valid.
REQ-010 in_ready  output  1  Beat accepted when in_valid && in_ready.
REQ-011 in_data  input  64  Eight data bytes.
REQ-012 in_para  input  64  Eight parameter bytes, always signed.
REQ-013 tree_data  output  64  Registered operand to the add tree.
REQ-014 tree_para  output  64  Registered operand to the add tree.
REQ-015 tree_signed  output  1  Signedness to the add tree.
REQ-016 tree_result  input  19  Add-tree dot-product result, two's complement.
REQ-017 out_valid  output  1  Result valid.
REQ-018 out_ready  input  1  Result consumed when out_valid && out_ready.
REQ-019 out_result  output  ACC_W  Accumulated dot product, two's complement.

Function
REQ-020 The FSM SHALL have four states: IDLE, FEED, DRAIN and HOLD.
REQ-021 IDLE: in_ready=0; start=1 latches cfg_len and cfg_signed, clears acc and the beat counter, and moves to FEED on the next edge.
REQ-022 start SHALL be ignored in FEED, DRAIN and HOLD.
REQ-023 FEED: in_ready=1; each accepted beat registers in_data/in_para onto tree_data/tree_para and increments the beat counter.
REQ-024 In any cycle with no accepted beat, tree_data and tree_para SHALL be registered to 0.
REQ-025 tree_signed SHALL equal the latched cfg_signed from the start edge until return to IDLE.
REQ-026 A (1+TREE_LAT)-deep valid-tag shift register SHALL track in-flight beats; acc += sign_extend(tree_result) only in the cycle a tag emerges.
REQ-027 tree_result SHALL always be sign-extended to ACC_W, in both signed and unsigned modes; acc wraps modulo 2^ACC_W.
REQ-028 When the accepted-beat count reaches cfg_len+1, the FSM SHALL move to DRAIN; in_ready is low from the following cycle.
REQ-029 DRAIN: in_ready=0; when the tag pipeline is empty and the final accumulate has completed, move to HOLD.
REQ-030 out_valid SHALL first be high exactly TREE_LAT+2 cycles after the edge that accepts the last beat.
REQ-031 HOLD: out_valid=1 and out_result=acc, both stable until out_valid && out_ready; then move to IDLE with out_valid=0 on the next edge.
REQ-032 in_valid bubbles in FEED SHALL not alter the result; only the latency stretches.
REQ-033 out_result SHALL hold its last value while out_valid=0.

Reset
REQ-034 rst=1 SHALL force state IDLE, clear acc, the beat counter and all tags, and drive busy, in_ready, out_valid, tree_signed, tree_data, tree_para and out_result to 0.
REQ-035 rst asserted mid-job SHALL abandon the job: no out_valid for it, and no in-flight tree_result is accumulated after reset.
REQ-036 rst SHALL take priority over start, in_valid and out_ready in the same cycle.

Verification
REQ-037 rst high for 2 cycles -> busy=0, in_ready=0, out_valid=0, tree_data=0, out_result=0.
REQ-038 Signed, cfg_len=0, in_data=0xFFFF..FF, in_para=0x0101..01 -> out_result=0xFFFFFFF8 (-8), out_valid high at TREE_LAT+2 after acceptance.
REQ-039 Unsigned, cfg_len=3, four beats of in_data=0xFF.., in_para=0x01.. with in_valid toggling every other cycle -> out_result=8160.
REQ-040 Signed, cfg_len=255, 256 beats of 0x80.. x 0x80.. -> out_result=0x02000000 with no wrap.
REQ-041 out_ready held low 5 cycles in HOLD, start pulsed -> out_valid and out_result stable, start ignored, IDLE after out_ready.
REQ-042 rst after 2 of 4 beats, then a new 1-beat unsigned job 0x01.. x 0x01.. -> out_result=8, no stale contribution.

Source files
------------

// File: rtl/npu_dot_seq.sv
// Dot-product sequencer: feeds operand beats to an external 8-lane add tree,
// accumulates the tree results as they emerge, and holds the sum for the consumer.
module npu_dot_seq #(
  parameter int TREE_LAT = 1,
  parameter int ACC_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [7:0]       cfg_len,
  input  logic             cfg_signed,
  output logic             busy,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [63:0]      in_data,
  input  logic [63:0]      in_para,
  output logic [63:0]      tree_data,
  output logic [63:0]      tree_para,
  output logic             tree_signed,
  input  logic [18:0]      tree_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_result,
  output logic [1:0]       dbg_state
);

  // Handshakes: a beat moves on any edge where in_valid && in_ready; the result
  // is taken on any edge where out_valid && out_ready. Neither valid waits on ready.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t             state, state_nxt;
  logic [7:0]         len_q;
  logic [8:0]         beat_cnt;
  logic [ACC_W-1:0]   acc;
  logic [TREE_LAT:0]  tags;
  logic [TREE_LAT:0]  tag_in;
  logic               accept;
  logic               last_beat;
  logic               tag_out;
  logic [ACC_W-1:0]   tree_ext;

  assign accept    = in_valid && in_ready;
  assign last_beat = accept && (beat_cnt == {1'b0, len_q});
  assign tag_in    = (TREE_LAT + 1)'(accept);
  assign tag_out   = tags[TREE_LAT];
  // Tree output is always two's complement, regardless of data signedness.
  assign tree_ext  = {{(ACC_W - 19){tree_result[18]}}, tree_result};
  assign dbg_state = state;

  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = FEED;
      end
      FEED: begin
        in_ready = 1'b1;
        if (last_beat) state_nxt = DRAIN;
      end
      DRAIN: begin
        // Empty tag pipe means the last tree result has already been summed.
        if (tags == '0) state_nxt = HOLD;
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      len_q       <= '0;
      beat_cnt    <= '0;
      acc         <= '0;
      tags        <= '0;
      tree_data   <= '0;
      tree_para   <= '0;
      tree_signed <= 1'b0;
      out_result  <= '0;
    end else begin
      state     <= state_nxt;
      tags      <= (tags << 1) | tag_in;
      tree_data <= accept ? in_data : '0;
      tree_para <= accept ? in_para : '0;
      if (state == IDLE && start) begin
        len_q       <= cfg_len;
        tree_signed <= cfg_signed;
        beat_cnt    <= '0;
        acc         <= '0;
      end else begin
        if (accept)  beat_cnt <= beat_cnt + 9'd1;
        if (tag_out) acc      <= acc + tree_ext;
      end
      // Separate result register so the visible value survives the next job's clear.
      if (state == DRAIN && state_nxt == HOLD) out_result <= acc;
      if (state == HOLD && out_ready) tree_signed <= 1'b0;
    end
  end

endmodule

// File: tb/tb_npu_dot_seq.sv
// Bench for npu_dot_seq: models the external add tree, drives directed and
// random jobs, and compares results against a plain-arithmetic reference.
module tb_npu_dot_seq;
  localparam int TL = 1;
  localparam int AW = 32;

  logic          clk, rst, start, cfg_signed, busy, in_valid, in_ready;
  logic [7:0]    cfg_len;
  logic [63:0]   in_data, in_para, tree_data, tree_para;
  logic          tree_signed, out_valid, out_ready;
  logic [18:0]   tree_result;
  logic [AW-1:0] out_result;
  logic [1:0]    dbg_state;

  logic [63:0]   bd [256];
  logic [63:0]   bp [256];
  logic [31:0]   exp_q[$];
  logic [31:0]   prev_exp;
  int            n_cmp, n_err;

  npu_dot_seq #(.TREE_LAT(TL), .ACC_W(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_len(cfg_len), .cfg_signed(cfg_signed),
    .busy(busy), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_para(in_para), .tree_data(tree_data), .tree_para(tree_para),
    .tree_signed(tree_signed), .tree_result(tree_result), .out_valid(out_valid),
    .out_ready(out_ready), .out_result(out_result), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, summary %0d compared / %0d mismatched", n_cmp, n_err + 1);
    $fatal(1);
  end

  // external add tree: combinational dot product followed by TL register stages
  function automatic logic [18:0] tree_fn(input logic [63:0] d, input logic [63:0] p, input logic s);
    int sum = 0;
    for (int l = 0; l < 8; l++) begin
      byte db, pb;
      int  dv;
      db = d[8*l +: 8];
      pb = p[8*l +: 8];
      dv = s ? int'(db) : int'(d[8*l +: 8]);
      sum += dv * int'(pb);
    end
    return 19'(sum);
  endfunction

  logic [18:0] pipe [TL];
  initial for (int i = 0; i < TL; i++) pipe[i] = '0;
  always @(posedge clk) begin
    pipe[0] <= tree_fn(tree_data, tree_para, tree_signed);
    for (int i = 1; i < TL; i++) pipe[i] <= pipe[i-1];
  end
  assign tree_result = pipe[TL-1];

  // reference: sum of lane products over all beats, modulo 2^32
  function automatic logic [31:0] ref_dot(input int n, input logic sgn);
    longint acc = 0;
    for (int b = 0; b < n; b++)
      for (int l = 0; l < 8; l++) begin
        longint dv, pv;
        dv = sgn ? longint'($signed(bd[b][8*l +: 8])) : longint'(bd[b][8*l +: 8]);
        pv = longint'($signed(bp[b][8*l +: 8]));
        acc += dv * pv;
      end
    return acc[31:0];
  endfunction

  // driver tasks
  task automatic do_reset(input int cycles);
    rst = 1'b1;
    repeat (cycles) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic start_job(input logic [7:0] len, input logic sgn);
    start = 1'b1; cfg_len = len; cfg_signed = sgn;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // mode 0: always valid, 1: alternating bubbles, 2: random bubbles
  task automatic feed(input int n, input int mode, output int fed);
    int   cyc = 0;
    logic tog = 1'b0;
    logic v, took;
    fed = 0;
    while (fed < n && cyc < 4 * n + 50) begin
      if (mode == 0) v = 1'b1;
      else if (mode == 1) begin v = tog; tog = ~tog; end
      else v = ($urandom_range(0, 3) != 0);
      in_valid = v; in_data = bd[fed]; in_para = bp[fed];
      took = v && in_ready;
      @(posedge clk); #1;
      if (took) fed++;
      cyc++;
    end
    in_valid = 1'b0;
  endtask

  // edges from now until out_valid rises; -1 if it never does
  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) lat = -1;
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic fill(input int n, input logic [63:0] d, input logic [63:0] p);
    for (int i = 0; i < n; i++) begin bd[i] = d; bp[i] = p; end
  endtask

  // tests
  task automatic test_reset();
    start = 1'b1; in_valid = 1'b1; out_ready = 1'b1; cfg_len = 8'd0; cfg_signed = 1'b1;
    in_data = '1; in_para = '1;
    do_reset(2);
    start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_cmp++; if (tree_data !== 64'd0) begin n_err++; $display("FAIL reset_tree_data: got %h expected 0", tree_data); end
    n_cmp++; if (tree_para !== 64'd0) begin n_err++; $display("FAIL reset_tree_para: got %h expected 0", tree_para); end
    n_cmp++; if (tree_signed !== 1'b0) begin n_err++; $display("FAIL reset_tree_signed: got %b expected 0", tree_signed); end
    n_cmp++; if (out_result !== 32'd0) begin n_err++; $display("FAIL reset_out_result: got %h expected 0", out_result); end
  endtask

  task automatic test_signed_single();
    int fed, lat;
    logic [31:0] e;
    fill(1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0101_0101_0101_0101);
    exp_q.push_back(32'hFFFF_FFF8);
    start_job(8'd0, 1'b1);
    n_cmp++; if (tree_signed !== 1'b1) begin n_err++; $display("FAIL single_tree_signed: got %b expected 1", tree_signed); end
    feed(1, 0, fed);
    n_cmp++; if (fed !== 1) begin n_err++; $display("FAIL single_fed: got %0d expected 1", fed); end
    wait_out(lat);
    n_cmp++; if (lat !== TL + 2) begin n_err++; $display("FAIL single_latency: got %0d expected %0d", lat, TL + 2); end
    e = exp_q.pop_front();
    n_cmp++; if (out_result !== e) begin n_err++; $display("FAIL single_result: got %h expected %h", out_result, e); end
    release_out();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL single_out_valid_drop: got %b expected 0", out_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL single_idle: got %b expected 0", busy); end
    n_cmp++; if (tree_signed !== 1'b0) begin n_err++; $display("FAIL single_signed_clear: got %b expected 0", tree_signed); end
    n_cmp++; if (out_result !== e) begin n_err++; $display("FAIL single_result_kept: got %h expected %h", out_result, e); end
  endtask

  task automatic test_unsigned_bubbles();
    int fed, lat;
    logic [31:0] e;
    fill(4, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0101_0101_0101_0101);
    exp_q.push_back(32'd8160);
    start_job(8'd3, 1'b0);
    feed(4, 1, fed);
    n_cmp++; if (fed !== 4) begin n_err++; $display("FAIL bubbles_fed: got %0d expected 4", fed); end
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bubbles_ready_low: got %b expected 0", in_ready); end
    wait_out(lat);
    n_cmp++; if (lat !== TL + 2) begin n_err++; $display("FAIL bubbles_latency: got %0d expected %0d", lat, TL + 2); end
    e = exp_q.pop_front();
    n_cmp++; if (out_result !== e) begin n_err++; $display("FAIL bubbles_result: got %h expected %h", out_result, e); end
    release_out();
  endtask

  task automatic test_long_signed();
    int fed, lat;
    logic [31:0] e;
    fill(256, 64'h8080_8080_8080_8080, 64'h8080_8080_8080_8080);
    exp_q.push_back(32'h0200_0000);
    start_job(8'd255, 1'b1);
    feed(256, 0, fed);
    n_cmp++; if (fed !== 256) begin n_err++; $display("FAIL long_fed: got %0d expected 256", fed); end
    wait_out(lat);
    n_cmp++; if (lat !== TL + 2) begin n_err++; $display("FAIL long_latency: got %0d expected %0d", lat, TL + 2); end
    e = exp_q.pop_front();
    n_cmp++; if (out_result !== e) begin n_err++; $display("FAIL long_result: got %h expected %h", out_result, e); end
    release_out();
  endtask

  task automatic test_hold_backpressure();
    int fed, lat;
    logic [31:0] e;
    bd[0] = {$urandom, $urandom}; bp[0] = {$urandom, $urandom};
    exp_q.push_back(ref_dot(1, 1'b1));
    start_job(8'd0, 1'b1);
    feed(1, 0, fed);
    wait_out(lat);
    e = exp_q.pop_front();
    for (int c = 0; c < 5; c++) begin
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL hold_valid_c%0d: got %b expected 1", c, out_valid); end
      n_cmp++; if (out_result !== e) begin n_err++; $display("FAIL hold_result_c%0d: got %h expected %h", c, out_result, e); end
      start = (c == 2); cfg_len = 8'd7;
      @(posedge clk); #1;
    end
    start = 1'b0;
    n_cmp++; if (dbg_state !== 2'd3) begin n_err++; $display("FAIL hold_state: got %0d expected 3", dbg_state); end
    release_out();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL hold_release_idle: got %b expected 0", busy); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL hold_release_valid: got %b expected 0", out_valid); end
  endtask

  task automatic test_reset_midjob();
    int fed, lat;
    logic [31:0] e;
    fill(4, 64'hFFFF_FFFF_FFFF_FFFF, 64'h7F7F_7F7F_7F7F_7F7F);
    start_job(8'd3, 1'b0);
    feed(2, 0, fed);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy: got %b expected 0", busy); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL midrst_valid: got %b expected 0", out_valid); end
    fill(1, 64'h0101_0101_0101_0101, 64'h0101_0101_0101_0101);
    exp_q.push_back(32'd8);
    start_job(8'd0, 1'b0);
    feed(1, 0, fed);
    wait_out(lat);
    n_cmp++; if (lat !== TL + 2) begin n_err++; $display("FAIL midrst_latency: got %0d expected %0d", lat, TL + 2); end
    e = exp_q.pop_front();
    n_cmp++; if (out_result !== e) begin n_err++; $display("FAIL midrst_result: got %h expected %h", out_result, e); end
    release_out();
    prev_exp = e;
  endtask

  task automatic test_random();
    int fed, lat, n, hold;
    logic sgn;
    logic [31:0] e;
    for (int j = 0; j < 20; j++) begin
      n   = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 40) : $urandom_range(1, 6);
      sgn = 1'($urandom_range(0, 1));
      for (int b = 0; b < n; b++) begin bd[b] = {$urandom, $urandom}; bp[b] = {$urandom, $urandom}; end
      exp_q.push_back(ref_dot(n, sgn));
      start_job(8'(n - 1), sgn);
      n_cmp++; if (out_result !== prev_exp) begin n_err++; $display("FAIL rnd%0d_prev_kept: got %h expected %h", j, out_result, prev_exp); end
      n_cmp++; if (tree_signed !== sgn) begin n_err++; $display("FAIL rnd%0d_tree_signed: got %b expected %b", j, tree_signed, sgn); end
      feed(n, 2, fed);
      n_cmp++; if (fed !== n) begin n_err++; $display("FAIL rnd%0d_fed: got %0d expected %0d", j, fed, n); end
      wait_out(lat);
      n_cmp++; if (lat !== TL + 2) begin n_err++; $display("FAIL rnd%0d_latency: got %0d expected %0d", j, lat, TL + 2); end
      e = exp_q.pop_front();
      hold = $urandom_range(0, 3);
      for (int c = 0; c <= hold; c++) begin
        n_cmp++; if (out_result !== e) begin n_err++; $display("FAIL rnd%0d_result_c%0d: got %h expected %h", j, c, out_result, e); end
        if (c < hold) begin @(posedge clk); #1; end
      end
      release_out();
      prev_exp = e;
    end
  endtask

  // sequence and report
  initial begin
    n_cmp = 0; n_err = 0; prev_exp = '0;
    rst = 1'b0; start = 1'b0; cfg_len = '0; cfg_signed = 1'b0;
    in_valid = 1'b0; in_data = '0; in_para = '0; out_ready = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_signed_single();
    test_unsigned_bubbles();
    test_long_signed();
    test_hold_backpressure();
    test_reset_midjob();
    test_random();
    n_cmp++; if (exp_q.size() !== 0) begin n_err++; $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
